// File: rtl/uart_tx_arb_if.sv
// ============================================================================
// Module   : uart_tx_arb_if
// Brief    : Requester and transmitter-side bundle for the shared UART TX arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface uart_tx_arb_if #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 2
);
  localparam int c_ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       gnt;
  logic                     tx_busy;
  logic [WIDTH-1:0]         tx_p_data;
  logic                     tx_data_valid;
  logic [c_ID_W-1:0]        active_id;
  logic                     arb_busy;
  logic                     to_err;

  // master: requesters plus the transmitter; slave: the arbiter itself
  modport master (
    output req, req_data, tx_busy,
    input  gnt, tx_p_data, tx_data_valid, active_id, arb_busy, to_err
  );

  modport slave (
    input  req, req_data, tx_busy,
    output gnt, tx_p_data, tx_data_valid, active_id, arb_busy, to_err
  );
endinterface

`default_nettype wire

// File: rtl/uart_tx_arb.sv
// ============================================================================
// Module   : uart_tx_arb
// Brief    : Round-robin arbiter/sequencer sharing one UART transmitter among
//            NUM_REQ byte producers, with start-pulse retry on missing BUSY.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx_arb #(
  parameter int WIDTH    = 8,
  parameter int NUM_REQ  = 2,
  parameter int START_TO = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  uart_tx_arb_if.slave bus
);
  localparam int                c_ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [c_ID_W-1:0] c_LAST_INIT = c_ID_W'(NUM_REQ - 1);
  localparam logic [3:0]        c_START_TO  = 4'(START_TO);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_START = 2'd1,
    S_WAIT_DONE  = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_ID_W-1:0]    r_last;
  logic [c_ID_W-1:0]    r_active_id;
  logic [3:0]           r_cnt;
  logic [NUM_REQ-1:0]   r_gnt;
  logic [WIDTH-1:0]     r_p_data;
  logic                 r_valid;
  logic                 r_arb_busy;
  logic                 r_to_err;

  logic [c_ID_W-1:0]    w_winner;
  logic [NUM_REQ-1:0]   w_gnt;
  logic [WIDTH-1:0]     w_win_data;
  logic                 w_any;

  // Winner is the requester with the smallest forward distance from the
  // last grant; distance wraps modulo NUM_REQ so non-power-of-2 counts work.
  always_comb begin
    int w_best;
    int w_dist;
    w_best     = NUM_REQ;
    w_dist     = 0;
    w_winner   = '0;
    w_gnt      = '0;
    w_win_data = '0;
    w_any      = |bus.req;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_dist = i - int'(r_last) - 1;
      if (w_dist < 0) w_dist = w_dist + NUM_REQ;
      if (bus.req[i] && (w_dist < w_best)) begin
        w_best     = w_dist;
        w_winner   = c_ID_W'(i);
        w_gnt      = '0;
        w_gnt[i]   = 1'b1;
        w_win_data = bus.req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_last      <= c_LAST_INIT;
      r_active_id <= '0;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_p_data    <= '0;
      r_valid     <= 1'b0;
      r_arb_busy  <= 1'b0;
      r_to_err    <= 1'b0;
    end else begin
      r_gnt    <= '0;
      r_valid  <= 1'b0;
      r_to_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A busy transmitter in IDLE is owned elsewhere or still draining.
          if (!bus.tx_busy && w_any) begin
            r_state     <= S_WAIT_START;
            r_arb_busy  <= 1'b1;
            r_gnt       <= w_gnt;
            r_p_data    <= w_win_data;
            r_valid     <= 1'b1;
            r_active_id <= w_winner;
            r_last      <= w_winner;
            r_cnt       <= '0;
          end
        end
        S_WAIT_START: begin
          if (bus.tx_busy) begin
            r_state <= S_WAIT_DONE;
          end else if (r_cnt == c_START_TO) begin
            r_valid  <= 1'b1;
            r_to_err <= 1'b1;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_WAIT_DONE: begin
          if (!bus.tx_busy) begin
            r_state    <= S_IDLE;
            r_arb_busy <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_arb_busy <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt           = r_gnt;
  assign bus.tx_p_data     = r_p_data;
  assign bus.tx_data_valid = r_valid;
  assign bus.active_id     = r_active_id;
  assign bus.arb_busy      = r_arb_busy;
  assign bus.to_err        = r_to_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
// ============================================================================
// Module   : tb_uart_tx_arb
// Brief    : Directed self-checking bench for uart_tx_arb (NUM_REQ=2 and 3).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_arb;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  uart_tx_arb_if #(.WIDTH(8), .NUM_REQ(2)) ifa ();
  uart_tx_arb_if #(.WIDTH(8), .NUM_REQ(3)) ifb ();

  uart_tx_arb #(.WIDTH(8), .NUM_REQ(2), .START_TO(3)) u_dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifa)
  );

  uart_tx_arb #(.WIDTH(8), .NUM_REQ(3), .START_TO(3)) u_dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_grant_a(input string tag, input logic [1:0] g, input logic [7:0] d,
                             input logic id);
    chk({tag, "_gnt"},   32'(ifa.gnt), 32'(g));
    chk({tag, "_data"},  32'(ifa.tx_p_data), 32'(d));
    chk({tag, "_id"},    32'(ifa.active_id), 32'(id));
    chk({tag, "_vld"},   32'(ifa.tx_data_valid), 32'd1);
    chk({tag, "_abusy"}, 32'(ifa.arb_busy), 32'd1);
  endtask

  task automatic chk_grant_b(input string tag, input logic [2:0] g, input logic [7:0] d,
                             input logic [1:0] id);
    chk({tag, "_gnt"},  32'(ifb.gnt), 32'(g));
    chk({tag, "_data"}, 32'(ifb.tx_p_data), 32'(d));
    chk({tag, "_id"},   32'(ifb.active_id), 32'(id));
  endtask

  // Transmitter for A: BUSY one cycle after the start pulse, held n cycles.
  task automatic serve_a(input int n, input string tag);
    tick();
    ifa.tx_busy = 1'b1;
    repeat (n) tick();
    chk({tag, "_busy"}, 32'(ifa.arb_busy), 32'd1);
    ifa.tx_busy = 1'b0;
    tick();
    chk({tag, "_idle"}, 32'(ifa.arb_busy), 32'd0);
    tick();
  endtask

  task automatic serve_b(input string tag);
    tick();
    ifb.tx_busy = 1'b1;
    tick();
    ifb.tx_busy = 1'b0;
    tick();
    chk({tag, "_idle"}, 32'(ifb.arb_busy), 32'd0);
    tick();
  endtask

  initial begin
    rst_n        = 1'b0;
    ifa.req      = '0;
    ifa.req_data = '0;
    ifa.tx_busy  = 1'b0;
    ifb.req      = '0;
    ifb.req_data = '0;
    ifb.tx_busy  = 1'b0;
    repeat (2) tick();

    // Reset state
    chk("rst_gnt",   32'(ifa.gnt), 32'd0);
    chk("rst_vld",   32'(ifa.tx_data_valid), 32'd0);
    chk("rst_data",  32'(ifa.tx_p_data), 32'd0);
    chk("rst_id",    32'(ifa.active_id), 32'd0);
    chk("rst_abusy", 32'(ifa.arb_busy), 32'd0);
    chk("rst_toerr", 32'(ifa.to_err), 32'd0);
    chk("rst_b_gnt", 32'(ifb.gnt), 32'd0);
    rst_n = 1'b1;

    // Contention: both held, grants alternate starting with req0
    ifa.req_data = 16'h2211;
    ifa.req      = 2'b11;
    tick();
    chk_grant_a("c0", 2'b01, 8'h11, 1'b0);
    serve_a(3, "c0");
    chk_grant_a("c1", 2'b10, 8'h22, 1'b1);
    serve_a(3, "c1");
    chk_grant_a("c2", 2'b01, 8'h11, 1'b0);
    serve_a(3, "c2");
    chk_grant_a("c3", 2'b10, 8'h22, 1'b1);
    ifa.req = 2'b00;
    serve_a(3, "c3");
    chk("c_none", 32'(ifa.gnt), 32'd0);

    // Single request with an 11-cycle frame
    ifa.req_data = 16'h5AA5;
    ifa.req      = 2'b01;
    tick();
    chk_grant_a("s", 2'b01, 8'hA5, 1'b0);
    ifa.req = 2'b00;
    tick();
    chk("s_vld_off", 32'(ifa.tx_data_valid), 32'd0);
    chk("s_gnt_off", 32'(ifa.gnt), 32'd0);
    chk("s_abusy",   32'(ifa.arb_busy), 32'd1);
    ifa.tx_busy = 1'b1;
    repeat (11) tick();
    chk("s_hold",  32'(ifa.arb_busy), 32'd1);
    chk("s_pdata", 32'(ifa.tx_p_data), 32'hA5);
    ifa.tx_busy = 1'b0;
    tick();
    chk("s_done",  32'(ifa.arb_busy), 32'd0);
    chk("s_pkeep", 32'(ifa.tx_p_data), 32'hA5);

    // Start timeout: retries every 4 cycles, same data, no re-grant
    ifa.req_data = 16'h3C00;
    ifa.req      = 2'b10;
    tick();
    chk_grant_a("t", 2'b10, 8'h3C, 1'b1);
    ifa.req = 2'b00;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk($sformatf("t_vld%0d", k),   32'(ifa.tx_data_valid), 32'((k % 4) == 0));
      chk($sformatf("t_toerr%0d", k), 32'(ifa.to_err), 32'((k % 4) == 0));
      chk($sformatf("t_gnt%0d", k),   32'(ifa.gnt), 32'd0);
      chk($sformatf("t_data%0d", k),  32'(ifa.tx_p_data), 32'h3C);
    end
    ifa.tx_busy = 1'b1;
    tick();
    chk("t_wd_vld",   32'(ifa.tx_data_valid), 32'd0);
    chk("t_wd_toerr", 32'(ifa.to_err), 32'd0);
    chk("t_wd_abusy", 32'(ifa.arb_busy), 32'd1);
    repeat (4) tick();
    chk("t_wd_quiet", 32'(ifa.tx_data_valid), 32'd0);
    ifa.tx_busy = 1'b0;
    tick();
    chk("t_end", 32'(ifa.arb_busy), 32'd0);

    // External busy blocks the grant until it falls
    ifa.tx_busy  = 1'b1;
    ifa.req_data = 16'h0077;
    ifa.req      = 2'b01;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("e_nognt%0d", k), 32'(ifa.gnt), 32'd0);
      chk($sformatf("e_idle%0d", k),  32'(ifa.arb_busy), 32'd0);
    end
    ifa.tx_busy = 1'b0;
    tick();
    chk_grant_a("e", 2'b01, 8'h77, 1'b0);
    ifa.req = 2'b00;
    serve_a(2, "e");

    // Asynchronous reset in WAIT_DONE
    ifa.req_data = 16'h9600;
    ifa.req      = 2'b10;
    tick();
    chk_grant_a("r", 2'b10, 8'h96, 1'b1);
    ifa.req = 2'b00;
    tick();
    ifa.tx_busy = 1'b1;
    repeat (2) tick();
    chk("r_pre", 32'(ifa.arb_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("r_gnt",   32'(ifa.gnt), 32'd0);
    chk("r_vld",   32'(ifa.tx_data_valid), 32'd0);
    chk("r_data",  32'(ifa.tx_p_data), 32'd0);
    chk("r_id",    32'(ifa.active_id), 32'd0);
    chk("r_abusy", 32'(ifa.arb_busy), 32'd0);
    chk("r_toerr", 32'(ifa.to_err), 32'd0);
    tick();
    rst_n   = 1'b1;
    ifa.req = 2'b10;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk($sformatf("r_wait_gnt%0d", k), 32'(ifa.gnt), 32'd0);
      chk($sformatf("r_wait_ab%0d", k),  32'(ifa.arb_busy), 32'd0);
    end
    ifa.tx_busy = 1'b0;
    tick();
    chk_grant_a("r2", 2'b10, 8'h96, 1'b1);
    ifa.req = 2'b00;
    serve_a(2, "r2");

    // NUM_REQ=3 round robin after reset (last=2) with wrap
    ifb.req_data = 24'h332211;
    ifb.req      = 3'b110;
    tick();
    chk_grant_b("b0", 3'b010, 8'h22, 2'd1);
    serve_b("b0");
    chk_grant_b("b1", 3'b100, 8'h33, 2'd2);
    serve_b("b1");
    chk_grant_b("b2", 3'b010, 8'h22, 2'd1);
    ifb.req = 3'b011;
    serve_b("b2");
    chk_grant_b("b3", 3'b001, 8'h11, 2'd0);
    ifb.req = 3'b000;
    serve_b("b3");
    chk("b_none", 32'(ifb.gnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Round-robin arbiter and sequencer sharing one UART transmitter (serializer/parity/mux TX path) between NUM_REQ byte producers (e.g. register-file read path, ALU result path).
- Accepts one byte per grant, drives the transmitter's parallel-data/data-valid inputs, and tracks its BUSY output to frame each transfer.
- Re-issues the start pulse if the transmitter fails to raise BUSY.

Parameters:
- WIDTH, 8, data byte width; must match the transmitter's data width.
- NUM_REQ, 2, number of requesters (2..8).
- START_TO, 3, cycles to wait for TX_BUSY rise after a start pulse before retrying (1..15).

Ports:
- CLK  input  1  system clock.
- RST  input  1  asynchronous active-low reset.
- REQ  input  NUM_REQ  per-requester level request; held until the matching GNT bit is seen.
- REQ_DATA  input  NUM_REQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH]; stable while REQ[i]=1.
- GNT  output  NUM_REQ  one-hot, one-cycle pulse; data of that requester was captured.
- TX_BUSY  input  1  BUSY from the transmitter.
- TX_P_DATA  output  WIDTH  parallel data to the transmitter.
- TX_DATA_VALID  output  1  one-cycle start pulse to the transmitter.
- ACTIVE_ID  output  clog2(NUM_REQ) (min 1)  index of the requester currently owning the transmitter.
- ARB_BUSY  output  1  high in every state except IDLE.
- TO_ERR  output  1  one-cycle pulse on each start timeout/retry.

Behaviour:
- All outputs registered. Reset (RST=0, async): state=IDLE, GNT=0, TX_P_DATA=0, TX_DATA_VALID=0, ACTIVE_ID=0, ARB_BUSY=0, TO_ERR=0, timeout counter=0, last-grant pointer=NUM_REQ-1 (so REQ[0] has top priority first).
- States: IDLE, WAIT_START, WAIT_DONE.
- IDLE: if TX_BUSY=0 and any REQ=1, pick the first set REQ scanning from (last+1) mod NUM_REQ upward with wrap. On that edge:
  - TX_P_DATA<=REQ_DATA[winner], TX_DATA_VALID<=1, GNT[winner]<=1, ACTIVE_ID<=winner, last<=winner, counter<=0.
  - Go to WAIT_START.
  - If TX_BUSY=1 in IDLE, no grant is issued (transmitter owned externally or still finishing).
- WAIT_START: TX_DATA_VALID and GNT return to 0 on the first edge in this state.
  - TX_BUSY=1 -> WAIT_DONE.
  - Otherwise counter increments each cycle. When counter reaches START_TO: TX_DATA_VALID<=1 again with the same held TX_P_DATA, TO_ERR<=1, counter<=0, stay in WAIT_START.
  - A retry never re-grants or re-samples REQ_DATA.
- WAIT_DONE: TX_BUSY=0 -> IDLE. A new grant can be issued on the following edge, so there is one idle cycle minimum between the BUSY fall and the next start pulse.
- TX_P_DATA holds its value from capture until the next grant; it is never changed mid-frame.
- ARB_BUSY = (state != IDLE), registered alongside state.
- REQ deassertion before grant: the request is simply not considered. REQ[i] still high on the cycle after its GNT is treated as a new request and is only served in a later IDLE.
- Simultaneous requests: exactly one GNT bit per grant. Round-robin guarantees each persistent requester is served within NUM_REQ grants.
- Reset mid-frame: the arbiter returns to IDLE immediately. If the transmitter is still busy, the arbiter waits in IDLE until TX_BUSY=0.
- Winner index width: clog2(NUM_REQ); pointer wrap uses modulo NUM_REQ, correct for non-power-of-2 NUM_REQ.

Test Plan:
- Single request: REQ=01, REQ_DATA[7:0]=0xA5; bench transmitter raises TX_BUSY 1 cycle after the start pulse and holds it 11 cycles -> GNT=01 for 1 cycle, TX_DATA_VALID one pulse with TX_P_DATA=0xA5, ACTIVE_ID=0, ARB_BUSY high until 1 cycle after TX_BUSY falls.
- Contention: REQ=11 held, data 0x11 (req0) and 0x22 (req1), 4 frames -> grant order 0,1,0,1, TX_P_DATA sequence 0x11,0x22,0x11,0x22, never two GNT bits in one cycle.
- Round-robin after wrap: NUM_REQ=3, last=2, REQ=110 -> req1 granted before req2; next grant goes to req2 if still requesting.
- Start timeout: TX_BUSY held 0 for 10 cycles after the grant, START_TO=3 -> retry start pulses every 4 cycles with TX_P_DATA unchanged, TO_ERR pulses each retry, no second GNT. Then TX_BUSY=1 -> WAIT_DONE.
- External busy: TX_BUSY=1 while REQ=01 in IDLE -> no GNT until TX_BUSY=0, then grant on the next edge.
- Async reset mid-frame: RST low during WAIT_DONE -> all outputs 0 immediately, ARB_BUSY=0. After release with TX_BUSY still 1 and REQ=10 -> grant to req1 only after TX_BUSY falls.
